// File: rtl/mk_pkg.sv
// mk_pkg -- shared definitions for the MK element path (packer and the
// buff_MK decoder).
//   mk_state_e   : packer FSM states (FILL accepting lanes, HOLD word waiting)
//   mk_flag_t    : 2-bit word flag carried alongside each packed word
//   FLAG_*       : flag encodings
//   mk_word_flag : flag selection for the element that completes a word
package mk_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } mk_state_e;

    typedef logic [1:0] mk_flag_t;

    localparam mk_flag_t FLAG_PLAIN = 2'b00;  // word ends cleanly
    localparam mk_flag_t FLAG_CONT  = 2'b01;  // VN spills into the next word
    localparam mk_flag_t FLAG_BLK   = 2'b10;  // parallel block ends here
    localparam mk_flag_t FLAG_ROW   = 2'b11;  // MK block row ends here

    // Row end implies block end, so it is tested first. Continuation only
    // matters when the word filled up naturally on its last lane.
    function automatic mk_flag_t mk_word_flag(input logic row_end,
                                              input logic blk_end,
                                              input logic last_lane,
                                              input logic vn_end);
        if (row_end)               return FLAG_ROW;
        if (blk_end)               return FLAG_BLK;
        if (last_lane && !vn_end)  return FLAG_CONT;
        return FLAG_PLAIN;
    endfunction

endpackage

// File: rtl/mk_fifo_packer_if.sv
// mk_fifo_packer_if -- element input handshake plus packed-word FIFO write
// port of mk_fifo_packer.
//   master : element source / FIFO side (testbench, upstream logic)
//   slave  : the packer itself
// Element side : i_valid, o_ready, i_data, i_dest, i_vn, i_vn_end,
//                i_block_end, i_row_end, i_clear
// FIFO side    : i_fifo_MK_full, o_fifo_wr_en, o_fifo_MK_data_in,
//                o_fifo_dest_in, o_fifo_vn_in, o_fifo_flag_in
interface mk_fifo_packer_if #(
    parameter int NUM_PES   = 8,
    parameter int LOG2_PES  = 3,
    parameter int LOG2_PEGS = 3,
    parameter int DATA_TYPE = 8
);
    logic                           i_valid;
    logic                           o_ready;
    logic [DATA_TYPE-1:0]           i_data;
    logic [LOG2_PES-1:0]            i_dest;
    logic [LOG2_PEGS-1:0]           i_vn;
    logic                           i_vn_end;
    logic                           i_block_end;
    logic                           i_row_end;
    logic                           i_clear;
    logic                           i_fifo_MK_full;
    logic                           o_fifo_wr_en;
    logic [DATA_TYPE*NUM_PES-1:0]   o_fifo_MK_data_in;
    logic [LOG2_PES*NUM_PES-1:0]    o_fifo_dest_in;
    logic [LOG2_PEGS*NUM_PES-1:0]   o_fifo_vn_in;
    logic [1:0]                     o_fifo_flag_in;

    modport master (
        output i_valid, i_data, i_dest, i_vn, i_vn_end, i_block_end,
               i_row_end, i_clear, i_fifo_MK_full,
        input  o_ready, o_fifo_wr_en, o_fifo_MK_data_in, o_fifo_dest_in,
               o_fifo_vn_in, o_fifo_flag_in
    );

    modport slave (
        input  i_valid, i_data, i_dest, i_vn, i_vn_end, i_block_end,
               i_row_end, i_clear, i_fifo_MK_full,
        output o_ready, o_fifo_wr_en, o_fifo_MK_data_in, o_fifo_dest_in,
               o_fifo_vn_in, o_fifo_flag_in
    );
endinterface

// File: rtl/mk_lane_regs.sv
// mk_lane_regs -- per-lane register file of the packed MK word.
//   clk, rst  : clock, async active-high reset (all lanes to zero)
//   clr       : zero every lane
//   we        : write (wdata, wdest, wvn) into lane idx
//   pad       : with we, the written element closes the word; lanes above
//               idx get data=0, dest=lane index, vn=0
//   o_data/o_dest/o_vn : packed word, lane k at [k*W +: W]
module mk_lane_regs #(
    parameter int NUM_PES   = 8,
    parameter int LOG2_PES  = 3,
    parameter int LOG2_PEGS = 3,
    parameter int DATA_TYPE = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          we,
    input  logic                          pad,
    input  logic [LOG2_PES-1:0]           idx,
    input  logic [DATA_TYPE-1:0]          wdata,
    input  logic [LOG2_PES-1:0]           wdest,
    input  logic [LOG2_PEGS-1:0]          wvn,
    output logic [DATA_TYPE*NUM_PES-1:0]  o_data,
    output logic [LOG2_PES*NUM_PES-1:0]   o_dest,
    output logic [LOG2_PEGS*NUM_PES-1:0]  o_vn
);
    logic [NUM_PES-1:0][DATA_TYPE-1:0] data_q;
    logic [NUM_PES-1:0][LOG2_PES-1:0]  dest_q;
    logic [NUM_PES-1:0][LOG2_PEGS-1:0] vn_q;

    for (genvar k = 0; k < NUM_PES; k++) begin : g_lane
        localparam logic [LOG2_PES-1:0] LANE = LOG2_PES'(k);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q[k] <= '0;
                dest_q[k] <= '0;
                vn_q[k]   <= '0;
            end else if (clr) begin
                data_q[k] <= '0;
                dest_q[k] <= '0;
                vn_q[k]   <= '0;
            end else if (we && idx == LANE) begin
                data_q[k] <= wdata;
                dest_q[k] <= wdest;
                vn_q[k]   <= wvn;
            end else if (we && pad && LANE > idx) begin
                // Padding keeps dest pointing at its own multiplier so the
                // distribution network sees a harmless zero per lane.
                data_q[k] <= '0;
                dest_q[k] <= LANE;
                vn_q[k]   <= '0;
            end
        end
    end

    assign o_data = data_q;
    assign o_dest = dest_q;
    assign o_vn   = vn_q;
endmodule

// File: rtl/mk_fifo_packer.sv
// mk_fifo_packer -- packs a stream of MK elements into NUM_PES-lane words and
// writes each word, with a 2-bit flag, into the downstream MK FIFO.
//   clk, rst : clock, async active-high reset
//   bus      : mk_fifo_packer_if.slave (element handshake + FIFO write port)
//   o_word_cnt, o_pad_cnt : (only with MK_PACKER_PERF_EN) saturating counts
//              of written words and padded lanes
// Optional feature macro: MK_PACKER_PERF_EN.
module mk_fifo_packer
    import mk_pkg::*;
#(
    parameter int NUM_PES   = 8,
    parameter int LOG2_PES  = 3,
    parameter int NUM_PEGS  = 8,
    parameter int LOG2_PEGS = 3,
    parameter int DATA_TYPE = 8
) (
    input  logic                clk,
    input  logic                rst,
    mk_fifo_packer_if.slave     bus
`ifdef MK_PACKER_PERF_EN
    ,
    output logic [31:0]         o_word_cnt,
    output logic [31:0]         o_pad_cnt
`endif
);
    if ((2 ** LOG2_PEGS) < NUM_PEGS) begin : g_bad_pegs
        $error("LOG2_PEGS too narrow for NUM_PEGS");
    end
    if ((2 ** LOG2_PES) < NUM_PES) begin : g_bad_pes
        $error("LOG2_PES too narrow for NUM_PES");
    end

    mk_state_e           state;
    logic [LOG2_PES-1:0] lane_cnt;
    mk_flag_t            flag_q;

    logic accept, take, clr, last_lane, flush, done;

    assign accept    = bus.i_valid && (state == ST_FILL);
    assign clr       = bus.i_clear && (state == ST_FILL);
    // A clear in the same cycle as an accept drops that element.
    assign take      = accept && !bus.i_clear;
    assign last_lane = (lane_cnt == LOG2_PES'(NUM_PES - 1));
    assign flush     = bus.i_block_end || bus.i_row_end;
    assign done      = take && (last_lane || flush);

    assign bus.o_ready      = (state == ST_FILL);
    // Write fires on the first HOLD cycle the FIFO has room, which gives the
    // one-cycle latency after the completing element.
    assign bus.o_fifo_wr_en = (state == ST_HOLD) && !bus.i_fifo_MK_full;
    assign bus.o_fifo_flag_in = flag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FILL;
            lane_cnt <= '0;
            flag_q   <= FLAG_PLAIN;
        end else begin
            case (state)
                ST_FILL: begin
                    if (clr) begin
                        lane_cnt <= '0;
                    end else if (take) begin
                        if (done) begin
                            state  <= ST_HOLD;
                            flag_q <= mk_word_flag(bus.i_row_end, bus.i_block_end,
                                                   last_lane, bus.i_vn_end);
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!bus.i_fifo_MK_full) begin
                        state    <= ST_FILL;
                        lane_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_FILL;
                    lane_cnt <= '0;
                end
            endcase
        end
    end

    mk_lane_regs #(
        .NUM_PES  (NUM_PES),
        .LOG2_PES (LOG2_PES),
        .LOG2_PEGS(LOG2_PEGS),
        .DATA_TYPE(DATA_TYPE)
    ) u_lanes (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .we    (take),
        .pad   (flush),
        .idx   (lane_cnt),
        .wdata (bus.i_data),
        .wdest (bus.i_dest),
        .wvn   (bus.i_vn),
        .o_data(bus.o_fifo_MK_data_in),
        .o_dest(bus.o_fifo_dest_in),
        .o_vn  (bus.o_fifo_vn_in)
    );

`ifdef MK_PACKER_PERF_EN
    // Pad count is captured with the word and only credited when the word is
    // actually written, so a reset during HOLD leaves the counters honest.
    logic [31:0] pad_q;
    logic [32:0] pad_sum;

    assign pad_sum = {1'b0, o_pad_cnt} + {1'b0, pad_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_q      <= '0;
            o_word_cnt <= '0;
            o_pad_cnt  <= '0;
        end else begin
            if (done) begin
                pad_q <= flush ? (32'(NUM_PES - 1) - 32'(lane_cnt)) : 32'd0;
            end
            if (bus.o_fifo_wr_en) begin
                if (o_word_cnt != '1) o_word_cnt <= o_word_cnt + 32'd1;
                o_pad_cnt <= pad_sum[32] ? '1 : pad_sum[31:0];
            end
        end
    end
`endif
endmodule

// File: tb/tb_mk_fifo_packer.sv
module tb_mk_fifo_packer;
    logic clk;
    logic rst;

    mk_fifo_packer_if bus();

`ifdef MK_PACKER_PERF_EN
    logic [31:0] word_cnt, pad_cnt;
`endif

    mk_fifo_packer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MK_PACKER_PERF_EN
        ,
        .o_word_cnt(word_cnt),
        .o_pad_cnt (pad_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [63:0] data;
        logic [23:0] dest;
        logic [23:0] vn;
        logic [1:0]  flag;
    } word_t;

    word_t wq[$];

    // Capture every write strobe at the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (bus.o_fifo_wr_en === 1'b1)
            wq.push_back({bus.o_fifo_MK_data_in, bus.o_fifo_dest_in,
                          bus.o_fifo_vn_in, bus.o_fifo_flag_in});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] de, input logic [2:0] v,
                        input logic ve, input logic blk, input logic row);
        bus.i_valid     = 1'b1;
        bus.i_data      = d;
        bus.i_dest      = de;
        bus.i_vn        = v;
        bus.i_vn_end    = ve;
        bus.i_block_end = blk;
        bus.i_row_end   = row;
        tick();
        bus.i_valid     = 1'b0;
        bus.i_vn_end    = 1'b0;
        bus.i_block_end = 1'b0;
        bus.i_row_end   = 1'b0;
    endtask

    // Element pattern: data = base+k, dest = 7-k, vn = k/2.
    task automatic check_word(input string name, input word_t got, input int base,
                              input int n, input logic [1:0] flag);
        logic [63:0] ed;
        logic [23:0] ede, ev;
        for (int k = 0; k < 8; k++) begin
            if (k < n) begin
                ed[k*8 +: 8]  = 8'(base + k);
                ede[k*3 +: 3] = 3'(7 - k);
                ev[k*3 +: 3]  = 3'(k / 2);
            end else begin
                ed[k*8 +: 8]  = 8'd0;
                ede[k*3 +: 3] = 3'(k);
                ev[k*3 +: 3]  = 3'd0;
            end
        end
        tests++;
        if (got.data !== ed || got.dest !== ede || got.vn !== ev || got.flag !== flag) begin
            fails++;
            $display("FAIL %s: got data=%h dest=%h vn=%h flag=%b, want data=%h dest=%h vn=%h flag=%b",
                     name, got.data, got.dest, got.vn, got.flag, ed, ede, ev, flag);
        end
    endtask

    task automatic check_cnt(input string name, input int want);
        tests++;
        if (wq.size() != want) begin
            fails++;
            $display("FAIL %s: writes=%0d want %0d", name, wq.size(), want);
        end
    endtask

    task automatic send_run(input int base, input int n, input logic last_ve,
                            input logic last_blk, input logic last_row);
        for (int k = 0; k < n; k++) begin
            if (k == n - 1) send(8'(base + k), 3'(7 - k), 3'(k / 2), last_ve, last_blk, last_row);
            else            send(8'(base + k), 3'(7 - k), 3'(k / 2), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tests++;
        if (bus.o_ready !== 1'b1 || bus.o_fifo_wr_en !== 1'b0 || bus.o_fifo_flag_in !== 2'b00 ||
            bus.o_fifo_MK_data_in !== 64'd0 || bus.o_fifo_dest_in !== 24'd0 ||
            bus.o_fifo_vn_in !== 24'd0) begin
            fails++;
            $display("FAIL reset: ready=%b wr=%b flag=%b data=%h dest=%h vn=%h, want 1 0 00 zeros",
                     bus.o_ready, bus.o_fifo_wr_en, bus.o_fifo_flag_in,
                     bus.o_fifo_MK_data_in, bus.o_fifo_dest_in, bus.o_fifo_vn_in);
        end
    endtask

    task automatic test_full_word();
        wq.delete();
        send_run(8'h11, 8, 1'b1, 1'b0, 1'b0);
        tick();  // write lands in the cycle right after the 8th accept
        check_cnt("full_word_count", 1);
        if (wq.size() > 0) check_word("full_word", wq[0], 8'h11, 8, 2'b00);
        tick();
        check_cnt("full_word_single", 1);
    endtask

    task automatic test_block_end();
        wq.delete();
        send_run(8'h40, 3, 1'b1, 1'b1, 1'b0);
        tick();
        check_cnt("block_end_count", 1);
        if (wq.size() > 0) check_word("block_end", wq[0], 8'h40, 3, 2'b10);
    endtask

    task automatic test_row_end();
        wq.delete();
        send_run(8'h60, 8, 1'b0, 1'b0, 1'b0);
        tick();
        check_cnt("row_first_count", 1);
        if (wq.size() > 0) check_word("row_cont", wq[0], 8'h60, 8, 2'b01);
        send_run(8'h70, 2, 1'b1, 1'b1, 1'b1);
        tick();
        check_cnt("row_second_count", 2);
        if (wq.size() > 1) check_word("row_end", wq[1], 8'h70, 2, 2'b11);
    endtask

    task automatic test_backpressure();
        word_t exp_w;
        wq.delete();
        bus.i_fifo_MK_full = 1'b1;
        send_run(8'h80, 8, 1'b1, 1'b0, 1'b0);
        exp_w = '{data: 64'h87868584_83828180, dest: 24'o01234567,
                  vn: 24'o33221100, flag: 2'b00};
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (bus.o_ready !== 1'b0 || bus.o_fifo_wr_en !== 1'b0 ||
                bus.o_fifo_MK_data_in !== exp_w.data || bus.o_fifo_dest_in !== exp_w.dest ||
                bus.o_fifo_vn_in !== exp_w.vn) begin
                fails++;
                $display("FAIL bp_hold[%0d]: ready=%b wr=%b data=%h dest=%h vn=%h, want 0 0 %h %h %h",
                         c, bus.o_ready, bus.o_fifo_wr_en, bus.o_fifo_MK_data_in,
                         bus.o_fifo_dest_in, bus.o_fifo_vn_in, exp_w.data, exp_w.dest, exp_w.vn);
            end
            tick();
        end
        bus.i_fifo_MK_full = 1'b0;
        #1;
        tests++;
        if (bus.o_fifo_wr_en !== 1'b1 || bus.o_fifo_MK_data_in !== exp_w.data) begin
            fails++;
            $display("FAIL bp_release: wr=%b data=%h, want 1 %h",
                     bus.o_fifo_wr_en, bus.o_fifo_MK_data_in, exp_w.data);
        end
        tick();
        tests++;
        if (bus.o_fifo_wr_en !== 1'b0 || bus.o_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_after: wr=%b ready=%b, want 0 1", bus.o_fifo_wr_en, bus.o_ready);
        end
        check_cnt("bp_count", 1);
        if (wq.size() > 0) check_word("bp_word", wq[0], 8'h80, 8, 2'b00);
    endtask

    task automatic test_clear();
        wq.delete();
        send_run(8'hA0, 4, 1'b0, 1'b0, 1'b0);
        // Clear together with a valid element: the element must be dropped.
        bus.i_clear = 1'b1;
        send(8'hEE, 3'd1, 3'd1, 1'b1, 1'b1, 1'b0);
        bus.i_clear = 1'b0;
        tick();
        check_cnt("clear_no_write", 0);
        tests++;
        if (bus.o_fifo_MK_data_in !== 64'd0 || bus.o_ready !== 1'b1) begin
            fails++;
            $display("FAIL clear_lanes: data=%h ready=%b, want 0 1",
                     bus.o_fifo_MK_data_in, bus.o_ready);
        end
        send_run(8'hB0, 8, 1'b1, 1'b0, 1'b0);
        tick();
        check_cnt("clear_next_count", 1);
        if (wq.size() > 0) check_word("clear_next", wq[0], 8'hB0, 8, 2'b00);
    endtask

    task automatic test_hold_reset();
        wq.delete();
        bus.i_fifo_MK_full = 1'b1;
        send_run(8'hC0, 3, 1'b1, 1'b1, 1'b0);
        tests++;
        if (bus.o_ready !== 1'b0 || bus.o_fifo_flag_in !== 2'b10) begin
            fails++;
            $display("FAIL hold_enter: ready=%b flag=%b, want 0 10", bus.o_ready, bus.o_fifo_flag_in);
        end
        rst = 1'b1;
        #1;
        bus.i_fifo_MK_full = 1'b0;
        tick();
        tests++;
        if (bus.o_fifo_wr_en !== 1'b0 || bus.o_fifo_flag_in !== 2'b00 ||
            bus.o_fifo_MK_data_in !== 64'd0 || bus.o_fifo_dest_in !== 24'd0 ||
            bus.o_fifo_vn_in !== 24'd0) begin
            fails++;
            $display("FAIL hold_rst_outputs: wr=%b flag=%b data=%h dest=%h vn=%h, want all 0",
                     bus.o_fifo_wr_en, bus.o_fifo_flag_in, bus.o_fifo_MK_data_in,
                     bus.o_fifo_dest_in, bus.o_fifo_vn_in);
        end
        rst = 1'b0;
        repeat (3) tick();
        check_cnt("hold_rst_no_write", 0);
        tests++;
        if (bus.o_ready !== 1'b1) begin
            fails++;
            $display("FAIL hold_rst_ready: ready=%b want 1", bus.o_ready);
        end
    endtask

    initial begin
        rst                = 1'b1;
        bus.i_valid        = 1'b0;
        bus.i_data         = '0;
        bus.i_dest         = '0;
        bus.i_vn           = '0;
        bus.i_vn_end       = 1'b0;
        bus.i_block_end    = 1'b0;
        bus.i_row_end      = 1'b0;
        bus.i_clear        = 1'b0;
        bus.i_fifo_MK_full = 1'b0;
        #1;
        test_reset();
        test_full_word();
        test_block_end();
        test_row_end();
        test_backpressure();
        test_clear();
        test_hold_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
